truth_table_sweeper: RTL
========================

// Module: truth_table_sweeper
// PURPOSE
//   Sequences a combinational logic block under test through every input vector.
//   Samples the block's outputs after a programmable settle time and assembles the full truth table.
//   Streams each row over a valid/ready port and compares the finished table against an expected table.
//   Sits between the minimizer's netlist-check harness and the combinational circuit being characterised.
// PARAMETERS
//   N_IN    4  input width of the swept block; table has 2**N_IN rows
//   N_OUT   2  output width of the swept block; bits per table row
//   SETTLE  1  cycles dut_x is held before the row is sampled (0 = sample in CAPTURE directly)
// PORTS
//   clk        in   1                   single clock, rising edge
//   rst_n      in   1                   asynchronous, active-low reset
//   start      in   1                   begin a sweep; accepted only in IDLE
//   dut_x      out  N_IN                input vector driven to block under test
//   dut_y      in   N_OUT               output of block under test
//   row_valid  out  1                   row_idx/row_y hold a sampled row
//   row_ready  in   1                   consumer accepts the row
//   row_idx    out  N_IN                index of the presented row (== dut_x)
//   row_y      out  N_OUT               sampled outputs for row_idx
//   expect_tt  in   N_OUT*2**N_IN       expected table, row i at [i*N_OUT +: N_OUT]
//   tt         out  N_OUT*2**N_IN       captured table, same packing
//   busy       out  1                   high from start acceptance until done
//   done       out  1                   one-cycle pulse at end of sweep
//   mismatch   out  1                   tt != expect_tt, updated with done and held
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, dut_x=0, idx=0, settle cnt=0, tt=0.
//     busy=0, done=0, mismatch=0, row_valid=0. Reset mid-sweep aborts immediately; no partial done.
//   FSM IDLE -> SETTLE -> CAPTURE -> (SETTLE | DONE) -> IDLE.
//   IDLE:    start=1 at edge -> tt cleared, idx=0, cnt=SETTLE, busy=1.
//            Next state is SETTLE, or CAPTURE if SETTLE==0.
//   SETTLE:  dut_x=idx held; cnt decrements each cycle; at cnt==1 the next state is CAPTURE.
//            Occupies exactly SETTLE cycles.
//   CAPTURE: row_valid=1, row_idx=idx, row_y=dut_y (live; stable since dut_x held).
//            Stays in CAPTURE while row_ready=0; dut_x/row_idx must not change (AXI-style: valid never drops).
//            On row_valid&row_ready edge: tt[idx*N_OUT +: N_OUT] <= dut_y.
//            If idx==2**N_IN-1, next state is DONE. Otherwise idx+1, cnt=SETTLE, and next state is
//            SETTLE (or CAPTURE if SETTLE==0).
//   DONE:    one cycle; done=1, busy=0. mismatch <= (tt_final != expect_tt).
//            Compare uses the final row written this cycle's edge. Next state is IDLE.
//   Latency: each row takes SETTLE+1 cycles with row_ready=1.
//            done is high in the cycle after edge 2**N_IN*(SETTLE+1), counted from the start-sampling edge.
//   Index wraps never: idx stops at 2**N_IN-1; a new sweep restarts at 0.
//   start while busy or in DONE is ignored (no queueing).
//   expect_tt is sampled only in DONE; it may change freely otherwise.
//   tt and mismatch hold their values in IDLE until the next accepted start (tt clears then).
//   dut_x holds last vector in IDLE after a sweep; it is 0 only after reset.
// TESTING
//   1. Reset values: rst_n=0 -> all outputs 0. Release, idle 10 cycles -> busy=0, row_valid=0.
//   2. 4-in/2-out test circuit attached, SETTLE=1, row_ready=1, start pulse ->
//      16 rows y=0,3,0,1,1,3,2,1,0,3,3,0,0,2,3,1; tt=0x783C6D4C.
//      done 33rd cycle; with expect_tt=0x783C6D4C, mismatch=0.
//   3. Same sweep with expect_tt=0x783C6D4D -> mismatch=1, held until next start.
//   4. row_ready low 5 cycles on row 7 -> row_valid stays 1, row_idx=7 and dut_x=7 stable.
//      tt unchanged until accept; done delayed by exactly 5 cycles.
//   5. start pulsed again at row 3 -> ignored. rst_n asserted at row 9 -> busy=0, tt=0, dut_x=0 asynchronously.
//      Fresh start completes normally.
//   6. SETTLE=0 build -> row_valid the cycle after start.
//      Done after 16 cycles with ready=1; table identical to test 2.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Walks a combinational block through every input vector, streams each sampled row
// over valid/ready, and flags whether the assembled truth table matches expect_tt.
module truth_table_sweeper #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic [N_IN-1:0]              dut_x,
  input  logic [N_OUT-1:0]             dut_y,
  output logic                         row_valid,
  input  logic                         row_ready,
  output logic [N_IN-1:0]              row_idx,
  output logic [N_OUT-1:0]             row_y,
  input  logic [N_OUT*(2**N_IN)-1:0]   expect_tt,
  output logic [N_OUT*(2**N_IN)-1:0]   tt,
  output logic                         busy,
  output logic                         done,
  output logic                         mismatch
);

  localparam int unsigned ROWS = 2**N_IN;
  localparam int unsigned TW   = N_OUT*ROWS;
  localparam int unsigned CW   = (SETTLE > 1) ? $clog2(SETTLE+1) : 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(SETTLE);
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tt_q, tt_d;
  logic              mm_q, mm_d;
  logic              mm_now;

  // A row that needs no settle time is presented straight away.
  localparam state_e ROW_ENTRY = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;

  assign mm_now = (tt_q != expect_tt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
      mm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      mm_q    <= mm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    mm_d    = mm_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          tt_d    = '0;
          idx_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = ROW_ENTRY;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (row_ready) begin
          tt_d[idx_q*N_OUT +: N_OUT] = dut_y;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            cnt_d   = CNT_INIT;
            state_d = ROW_ENTRY;
          end
        end
      end
      S_DONE: begin
        mm_d    = mm_now;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dut_x     = idx_q;
  assign row_idx   = idx_q;
  assign row_y     = dut_y;
  assign row_valid = (state_q == S_CAPTURE);
  assign busy      = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
  assign done      = (state_q == S_DONE);
  assign tt        = tt_q;
  // The verdict is already visible during the done pulse, then held.
  assign mismatch  = (state_q == S_DONE) ? mm_now : mm_q;

endmodule
